// File: rtl/data_mux_scheduler.sv
// data_mux_scheduler: round-robin slot scheduler sharing one symbol lane among three byte streams
module data_mux_scheduler #(
  parameter int DATA_W = 8,
  parameter int CNT_W = 3,
  parameter logic [DATA_W-1:0] FILL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              symbol_tick,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  switch_clk_cycles,
  input  logic [DATA_W-1:0] ds1_data,
  input  logic              ds1_valid,
  output logic              ds1_ready,
  input  logic [DATA_W-1:0] ds2_data,
  input  logic              ds2_valid,
  output logic              ds2_ready,
  input  logic [DATA_W-1:0] ds3_data,
  input  logic              ds3_valid,
  output logic              ds3_ready,
  output logic [DATA_W-1:0] mux_data,
  output logic              mux_valid,
  output logic [1:0]        mux_sel,
  output logic              frame_start,
  output logic              underrun
);
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
  state_t state, state_nx;
  logic [1:0] slot, mode_q;
  logic [CNT_W-1:0] cnt, dwell_q, cnt_inc, sw_eff;
  logic first_q, tick_act, sel_valid, dwell_end, wrap;
  logic [DATA_W-1:0] sel_data;
  assign tick_act = (state == ACTIVE) && symbol_tick;
  assign cnt_inc = cnt + CNT_W'(1);
  assign sw_eff = (switch_clk_cycles == '0) ? CNT_W'(1) : switch_clk_cycles;
  assign dwell_end = (cnt_inc == dwell_q);
  assign wrap = dwell_end && (slot == mode_q - 2'd1);
  assign sel_valid = (slot == 2'd0) ? ds1_valid : (slot == 2'd1) ? ds2_valid : ds3_valid;
  assign sel_data = (slot == 2'd0) ? ds1_data : (slot == 2'd1) ? ds2_data : ds3_data;
  assign ds1_ready = tick_act && (slot == 2'd0) && ds1_valid;
  assign ds2_ready = tick_act && (slot == 2'd1) && ds2_valid;
  assign ds3_ready = tick_act && (slot == 2'd2) && ds3_valid;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: a frame only ends into IDLE when the relatched mode is off
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = (mode != 2'd0) ? LOAD : IDLE;
    else if (state == LOAD) state_nx = (mode != 2'd0) ? ACTIVE : IDLE;
    else if (tick_act && wrap && mode == 2'd0) state_nx = IDLE;
  end
  // slot/dwell tracking and registered output lane
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot <= '0;
      cnt <= '0;
      mode_q <= '0;
      dwell_q <= '0;
      first_q <= 1'b0;
      mux_data <= '0;
      mux_valid <= 1'b0;
      mux_sel <= '0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
    end else begin
      mux_valid <= 1'b0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
      if (state == LOAD) begin
        mode_q <= mode;
        dwell_q <= sw_eff;
        slot <= '0;
        cnt <= '0;
        first_q <= 1'b1;
      end
      if (tick_act) begin
        mux_valid <= 1'b1;
        mux_data <= sel_valid ? sel_data : FILL;
        underrun <= !sel_valid;
        mux_sel <= slot;
        frame_start <= first_q;
        first_q <= 1'b0;
        cnt <= dwell_end ? '0 : cnt_inc;
        if (wrap) begin
          slot <= '0;
          first_q <= 1'b1;
          mode_q <= mode;
          dwell_q <= sw_eff;
        end else if (dwell_end) slot <= slot + 2'd1;
      end
    end
endmodule

// File: tb/tb_data_mux_scheduler.sv
// tb_data_mux_scheduler: directed checks of the slot scheduler
module tb_data_mux_scheduler;
  logic clk = 0, rst_n = 0, symbol_tick = 0;
  logic [1:0] mode = 0;
  logic [2:0] switch_clk_cycles = 0;
  logic [7:0] ds1_data = 8'd3, ds2_data = 8'd50, ds3_data = 8'd98;
  logic ds1_valid = 1, ds2_valid = 1, ds3_valid = 1;
  logic ds1_ready, ds2_ready, ds3_ready;
  logic [7:0] mux_data;
  logic mux_valid, frame_start, underrun;
  logic [1:0] mux_sel;
  logic [12:0] obs;
  logic [2:0] rdy;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  assign obs = {mux_valid, mux_sel, frame_start, underrun, mux_data};
  data_mux_scheduler dut (
    .clk(clk), .rst_n(rst_n), .symbol_tick(symbol_tick), .mode(mode),
    .switch_clk_cycles(switch_clk_cycles),
    .ds1_data(ds1_data), .ds1_valid(ds1_valid), .ds1_ready(ds1_ready),
    .ds2_data(ds2_data), .ds2_valid(ds2_valid), .ds2_ready(ds2_ready),
    .ds3_data(ds3_data), .ds3_valid(ds3_valid), .ds3_ready(ds3_ready),
    .mux_data(mux_data), .mux_valid(mux_valid), .mux_sel(mux_sel),
    .frame_start(frame_start), .underrun(underrun)
  );
  task automatic tick();
    @(negedge clk);
    symbol_tick = 1;
    #1 rdy = {ds3_ready, ds2_ready, ds1_ready};
    @(negedge clk);
    symbol_tick = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    mode = 0;
    symbol_tick = 0;
    ds1_valid = 1; ds2_valid = 1; ds3_valid = 1;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic start(input logic [1:0] m, input logic [2:0] sw);
    @(negedge clk);
    mode = m;
    switch_clk_cycles = sw;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset();
    do_reset();
    total++;
    if (obs !== 13'd0 || {ds3_ready, ds2_ready, ds1_ready} !== 3'b0)
      $display("FAIL reset_state got %h/%b want 0/000", obs, {ds3_ready, ds2_ready, ds1_ready});
    else pass++;
    tick();
    total++;
    if (obs !== 13'd0 || rdy !== 3'b0) $display("FAIL idle_tick got %h/%b want 0/000", obs, rdy);
    else pass++;
  endtask
  task automatic test_round_robin();
    logic [1:0] s;
    logic [7:0] d;
    do_reset();
    start(2'd3, 3'd2);
    for (int i = 0; i < 7; i++) begin
      s = (i == 6) ? 2'd0 : 2'(i / 2);
      d = (s == 2'd0) ? 8'd3 : (s == 2'd1) ? 8'd50 : 8'd98;
      tick();
      total++;
      if (obs !== {1'b1, s, (i == 0 || i == 6), 1'b0, d} || rdy !== (3'b001 << s))
        $display("FAIL rr_tick%0d got %h/%b want %h/%b", i + 1, obs, rdy, {1'b1, s, (i == 0 || i == 6), 1'b0, d}, 3'b001 << s);
      else pass++;
    end
    @(negedge clk);
    total++;
    if (mux_valid !== 1'b0 || mux_data !== 8'd3) $display("FAIL rr_hold got %b/%h want 0/03", mux_valid, mux_data);
    else pass++;
  endtask
  task automatic test_dwell_zero();
    do_reset();
    start(2'd2, 3'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (obs !== {1'b1, 2'(i % 2), (i % 2 == 0), 1'b0, (i % 2 == 0) ? 8'd3 : 8'd50})
        $display("FAIL dwell0_tick%0d got %h want %h", i + 1, obs, {1'b1, 2'(i % 2), (i % 2 == 0), 1'b0, (i % 2 == 0) ? 8'd3 : 8'd50});
      else pass++;
    end
  endtask
  task automatic test_underrun();
    do_reset();
    start(2'd3, 3'd1);
    ds2_valid = 0;
    tick();
    total++;
    if (obs !== {1'b1, 2'd0, 1'b1, 1'b0, 8'd3} || rdy !== 3'b001) $display("FAIL ur_tick1 got %h/%b want %h/001", obs, rdy, {1'b1, 2'd0, 1'b1, 1'b0, 8'd3});
    else pass++;
    tick();
    total++;
    if (obs !== {1'b1, 2'd1, 1'b0, 1'b1, 8'h00} || rdy !== 3'b000) $display("FAIL ur_tick2 got %h/%b want %h/000", obs, rdy, {1'b1, 2'd1, 1'b0, 1'b1, 8'h00});
    else pass++;
    tick();
    total++;
    if (obs !== {1'b1, 2'd2, 1'b0, 1'b0, 8'd98} || rdy !== 3'b100) $display("FAIL ur_tick3 got %h/%b want %h/100", obs, rdy, {1'b1, 2'd2, 1'b0, 1'b0, 8'd98});
    else pass++;
  endtask
  task automatic test_mode_change();
    logic [1:0] sels [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
    logic fs [9] = '{1, 0, 0, 0, 0, 0, 1, 0, 1};
    logic [7:0] d;
    do_reset();
    start(2'd3, 3'd2);
    for (int i = 0; i < 9; i++) begin
      if (i == 1) mode = 2'd1;
      tick();
      d = (sels[i] == 2'd0) ? 8'd3 : (sels[i] == 2'd1) ? 8'd50 : 8'd98;
      total++;
      if (obs !== {1'b1, sels[i], fs[i], 1'b0, d}) $display("FAIL modechg_tick%0d got %h want %h", i + 1, obs, {1'b1, sels[i], fs[i], 1'b0, d});
      else pass++;
    end
  endtask
  task automatic test_mode_off();
    do_reset();
    start(2'd2, 3'd1);
    tick();
    mode = 2'd0;
    tick();
    total++;
    if (obs !== {1'b1, 2'd1, 1'b0, 1'b0, 8'd50}) $display("FAIL off_last got %h want %h", obs, {1'b1, 2'd1, 1'b0, 1'b0, 8'd50});
    else pass++;
    tick();
    total++;
    if (obs !== {1'b0, 2'd1, 1'b0, 1'b0, 8'd50} || rdy !== 3'b000) $display("FAIL off_idle got %h/%b want %h/000", obs, rdy, {1'b0, 2'd1, 1'b0, 1'b0, 8'd50});
    else pass++;
  endtask
  task automatic test_back_to_back();
    logic [7:0] d;
    do_reset();
    start(2'd3, 3'd2);
    repeat (3) tick();
    @(negedge clk);
    rst_n = 0;
    #1;
    total++;
    if (obs !== 13'd0) $display("FAIL async_reset got %h want 0", obs);
    else pass++;
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    symbol_tick = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d = (i < 2) ? 8'd3 : (i < 4) ? 8'd50 : 8'd98;
      total++;
      if (obs !== {1'b1, 2'(i / 2), (i == 0), 1'b0, d}) $display("FAIL b2b_tick%0d got %h want %h", i + 1, obs, {1'b1, 2'(i / 2), (i == 0), 1'b0, d});
      else pass++;
    end
    symbol_tick = 0;
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_dwell_zero();
    test_underrun();
    test_mode_change();
    test_mode_off();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
